// File: rtl/multi_tick_generator.sv
// Bank of independent programmable tick generators sharing one sync strobe
// and one divisor-write port. Each channel runs periodic or one-shot.

module multi_tick_channel #(
  parameter int CNT_W   = 24,
  parameter int DEF_DIV = 100_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable_i,
  input  logic             oneshot_i,
  input  logic             sync_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_div_i,
  output logic             tick_o,
  output logic             busy_o
);
  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEF_DIV);

  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             tick_q, tick_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] term;

  // A zero divisor behaves like a divisor of one: wrap on every edge.
  assign term = (div_q == '0) ? '0 : div_q - CNT_W'(1);

  always_comb begin
    div_d  = div_q;
    cnt_d  = cnt_q;
    done_d = done_q;
    tick_d = 1'b0;
    busy_d = enable_i & ~done_q;
    if (wr_i) div_d = wr_div_i;
    if (sync_i || wr_i || !enable_i) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (done_q) begin
      cnt_d = '0;
    end else if (cnt_q == term) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      done_d = oneshot_i;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q  <= RST_DIV;
      cnt_q  <= '0;
      done_q <= 1'b0;
      tick_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
      tick_q <= tick_d;
      busy_q <= busy_d;
    end
  end

  assign tick_o = tick_q;
  assign busy_o = busy_q;
endmodule

module multi_tick_generator #(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 24,
  parameter int DEFAULT_DIV = 100_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  enable,
  input  logic [N_CH-1:0]  oneshot,
  input  logic             sync,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  busy
);
  logic [N_CH-1:0] wr;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    // Out-of-range channel indices match no instance and are dropped.
    assign wr[i] = cfg_we && (cfg_ch == 4'(i));

    multi_tick_channel #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .enable_i  (enable[i]),
      .oneshot_i (oneshot[i]),
      .sync_i    (sync),
      .wr_i      (wr[i]),
      .wr_div_i  (cfg_div),
      .tick_o    (tick[i]),
      .busy_o    (busy[i])
    );
  end
endmodule

// File: tb/tb_multi_tick_generator.sv
// Directed checks of multi_tick_generator with N_CH=2, CNT_W=8, DEFAULT_DIV=5.
module tb_multi_tick_generator;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] enable = '0;
  logic [1:0] oneshot = '0;
  logic       sync = 1'b0;
  logic       cfg_we = 1'b0;
  logic [3:0] cfg_ch = '0;
  logic [7:0] cfg_div = '0;
  logic [1:0] tick, busy;

  int vecs = 0;
  int errs = 0;

  multi_tick_generator #(.N_CH(2), .CNT_W(8), .DEFAULT_DIV(5)) dut (
    .clk(clk), .reset(reset), .enable(enable), .oneshot(oneshot), .sync(sync),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .tick(tick), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    enable = 2'b11;
    oneshot = 2'b10;
    cfg_we = 1'b1;
    cfg_ch = 4'd0;
    cfg_div = 8'd1;
    step();
    step();
    vecs++;
    if (tick !== 2'b00) begin errs++; $display("FAIL reset_tick got %b want 00", tick); end
    vecs++;
    if (busy !== 2'b00) begin errs++; $display("FAIL reset_busy got %b want 00", busy); end
    cfg_we = 1'b0;
    oneshot = 2'b00;
    enable = 2'b01;
    step();
    reset = 1'b0;
  endtask

  task automatic test_periodic();
    logic [1:0] exp;
    for (int k = 1; k <= 16; k++) begin
      step();
      exp = {1'b0, (k % 5) == 0};
      vecs++;
      if (tick !== exp) begin errs++; $display("FAIL periodic_k%0d got %b want %b", k, tick, exp); end
    end
    vecs++;
    if (busy !== 2'b01) begin errs++; $display("FAIL periodic_busy got %b want 01", busy); end
    enable = 2'b00;
    step();
  endtask

  task automatic test_oneshot();
    logic [1:0] exp;
    cfg_we = 1'b1; cfg_ch = 4'd1; cfg_div = 8'd3;
    step();
    cfg_we = 1'b0;
    enable = 2'b10;
    oneshot = 2'b10;
    for (int k = 1; k <= 23; k++) begin
      step();
      exp = (k == 3) ? 2'b10 : 2'b00;
      vecs++;
      if (tick !== exp) begin errs++; $display("FAIL oneshot_tick_k%0d got %b want %b", k, tick, exp); end
      exp = (k <= 3) ? 2'b10 : 2'b00;
      vecs++;
      if (busy !== exp) begin errs++; $display("FAIL oneshot_busy_k%0d got %b want %b", k, busy, exp); end
    end
    enable = 2'b00;
    oneshot = 2'b00;
    step();
  endtask

  task automatic test_sync();
    logic [1:0] exp;
    enable = 2'b01;
    for (int k = 1; k <= 12; k++) begin
      sync = (k == 5);
      step();
      exp = {1'b0, k == 10};
      vecs++;
      if (tick !== exp) begin errs++; $display("FAIL sync_k%0d got %b want %b", k, tick, exp); end
    end
    sync = 1'b0;
    enable = 2'b00;
    step();
  endtask

  task automatic test_div_edge();
    cfg_we = 1'b1; cfg_ch = 4'd0; cfg_div = 8'd0;
    step();
    cfg_we = 1'b0;
    enable = 2'b01;
    for (int k = 1; k <= 4; k++) begin
      step();
      vecs++;
      if (tick !== 2'b01) begin errs++; $display("FAIL div0_k%0d got %b want 01", k, tick); end
    end
    cfg_we = 1'b1; cfg_div = 8'd1;
    step();
    cfg_we = 1'b0;
    vecs++;
    if (tick !== 2'b00) begin errs++; $display("FAIL div_write_tick got %b want 00", tick); end
    for (int k = 1; k <= 4; k++) begin
      step();
      vecs++;
      if (tick !== 2'b01) begin errs++; $display("FAIL div1_k%0d got %b want 01", k, tick); end
    end
    enable = 2'b00;
    step();
  endtask

  task automatic test_bad_ch();
    logic [1:0] exp;
    cfg_we = 1'b1; cfg_ch = 4'd0; cfg_div = 8'd5;
    step();
    cfg_we = 1'b1; cfg_ch = 4'd3; cfg_div = 8'd1;
    enable = 2'b11;
    for (int k = 1; k <= 15; k++) begin
      step();
      cfg_we = 1'b0;
      exp = {(k % 3) == 0, (k % 5) == 0};
      vecs++;
      if (tick !== exp) begin errs++; $display("FAIL badch_k%0d got %b want %b", k, tick, exp); end
    end
    enable = 2'b00;
    step();
  endtask

  task automatic test_reset_mid();
    logic [1:0] exp;
    enable = 2'b01;
    step(); step(); step();
    reset = 1'b1;
    #1;
    vecs++;
    if (tick !== 2'b00) begin errs++; $display("FAIL rstmid_tick got %b want 00", tick); end
    vecs++;
    if (busy !== 2'b00) begin errs++; $display("FAIL rstmid_busy got %b want 00", busy); end
    step();
    reset = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      exp = {1'b0, k == 5};
      vecs++;
      if (tick !== exp) begin errs++; $display("FAIL rstmid_k%0d got %b want %b", k, tick, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_oneshot();
    test_sync();
    test_div_edge();
    test_bad_ch();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/multi_tick_generator.md
MULTI_TICK_GENERATOR -- requirements
Module: multi_tick_generator

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent tick channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 24: width of divisor and counter per channel.
REQ-003 SHALL have parameter DEFAULT_DIV, default 100_000: divisor loaded into every channel at reset (1 kHz at 100 MHz).
REQ-004 SHALL have port clk, input, 1: rising-edge clock.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port enable, input, N_CH: per-channel run enable.
REQ-007 SHALL have port oneshot, input, N_CH: per-channel mode; 0 = periodic, 1 = one-shot.
REQ-008 SHALL have port sync, input, 1: single-cycle restart of all channel counters.
REQ-009 SHALL have port cfg_we, input, 1: divisor write strobe.
REQ-010 SHALL have port cfg_ch, input, 4: channel index for divisor write.
REQ-011 SHALL have port cfg_div, input, CNT_W: divisor value for write.
REQ-012 SHALL have port tick, output, N_CH: registered one-clock pulses.
REQ-013 SHALL have port busy, output, N_CH: registered; channel is counting toward a tick.

Function
REQ-014 Each channel i SHALL hold a divisor register div[i] and a counter cnt[i], both CNT_W bits.
REQ-015 Effective divisor SHALL be D = max(div[i], 1); div[i] = 0 behaves as D = 1.
REQ-016 Counting: while enable[i]=1 and channel not done, cnt[i] SHALL increment by 1 per clock, wrapping to 0 on the clock where cnt[i] == D-1.
REQ-017 tick[i] SHALL be 1 for exactly the one cycle following the edge on which cnt[i] wrapped; 0 otherwise.
REQ-018 Periodic mode: with enable held high from cnt=0, ticks SHALL occur every D cycles, first tick visible after the D-th rising edge.
REQ-019 D = 1 in periodic mode SHALL hold tick[i] high every cycle while enabled.
REQ-020 One-shot mode: after the first tick, the channel SHALL set an internal done flag, hold cnt[i] at 0, and emit no further ticks.
REQ-021 done SHALL clear on enable[i] falling to 0, on sync, or on a divisor write to channel i.
REQ-022 enable[i]=0 SHALL clear cnt[i] to 0 and drive tick[i]=0 on the next edge; no tick is produced in that cycle.
REQ-023 sync=1 SHALL clear all cnt[] and done flags and force all tick[] to 0 on that edge, overriding any simultaneous terminal count.
REQ-024 cfg_we=1 with cfg_ch < N_CH SHALL load div[cfg_ch] <= cfg_div, clear cnt[cfg_ch] and done, and force tick[cfg_ch]=0 on that edge.
REQ-025 cfg_we=1 with cfg_ch >= N_CH SHALL have no effect.
REQ-026 sync and cfg_we in the same cycle SHALL both take effect.
REQ-027 busy[i] SHALL equal enable[i] AND NOT done[i] as sampled on the previous edge (registered).
REQ-028 Channels SHALL be fully independent except for the shared sync and cfg port.
REQ-029 Counter arithmetic SHALL be unsigned CNT_W bits; DEFAULT_DIV and cfg_div > 2^CNT_W-1 are truncated.

Reset
REQ-030 reset=1 SHALL asynchronously set all cnt[] = 0, done = 0, tick = 0, busy = 0, div[] = DEFAULT_DIV.
REQ-031 reset asserted mid-count SHALL abort any pending tick; first tick after release follows REQ-018 timing.
REQ-032 Outputs SHALL remain at reset values while reset is high regardless of other inputs.

Verification (bench parameters N_CH=2, CNT_W=8, DEFAULT_DIV=5)
REQ-033 Reset release, enable=2'b01, oneshot=0 -> tick[0] high on cycles 5, 10, 15 after release; tick[1] stays 0.
REQ-034 cfg_we, cfg_ch=1, cfg_div=3, then enable=2'b10, oneshot[1]=1 -> single tick[1] 3 cycles later, busy[1] drops, no further ticks over 20 cycles.
REQ-035 Channel 0 periodic D=5, sync asserted on cycle where cnt[0]=4 -> no tick that cycle; next tick 5 cycles after sync.
REQ-036 cfg_div=0 and cfg_div=1 on channel 0, enabled -> tick[0] high every cycle in both cases.
REQ-037 cfg_we with cfg_ch=3 -> div[0], div[1] unchanged, tick timing unaffected.
REQ-038 reset pulsed while cnt[0]=3 -> tick[0]=0 immediately; after release, next tick at cycle 5.
